// File: rtl/xentry_pkg.sv
// Shared types for the L2 line responder: memory operation codes and the
// responder's transfer state encoding.
package xentry_pkg;

  typedef enum logic [1:0] {
    LOAD     = 2'd0,
    STORE    = 2'd1,
    PREFETCH = 2'd2,
    NOP      = 2'd3
  } memory_operation_e;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LATENCY   = 3'd1,
    FILL      = 3'd2,
    WRITEBACK = 3'd3,
    DONE      = 3'd4
  } l2_responder_state_e;

endpackage

// File: rtl/l2_line_responder_ram.sv
// Word-addressed backing store: single port, combinational read, synchronous
// write. Contents are never reset so they survive transfer aborts.
module l2_word_ram #(
  parameter int XLEN      = 32,
  parameter int MEM_WORDS = 1024,
  parameter int AW        = $clog2(MEM_WORDS)
) (
  input  logic            clk,
  input  logic            we,
  input  logic [AW-1:0]   addr,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] rdata
);

  logic [XLEN-1:0] mem_q [MEM_WORDS];

  // Synchronous word write
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
  end

  assign rdata = mem_q[addr];

endmodule

// File: rtl/l2_line_responder.sv
// Line-granular L2 model: serves whole-line fills after a fixed latency and
// absorbs whole-line writebacks paced by wvalid.
module l2_line_responder
  import xentry_pkg::*;
#(
  parameter int LINE_SIZE    = 32,
  parameter int XLEN         = 32,
  parameter int MEM_WORDS    = 1024,
  parameter int READ_LATENCY = 4,
  localparam int WORDS_PER_LINE   = LINE_SIZE / (XLEN / 8),
  localparam int WORD_SELECT_SIZE = $clog2(WORDS_PER_LINE)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  memory_operation_e           req_type,
  input  logic [XLEN-1:0]             req_address,
  input  logic                        wvalid,
  input  logic [XLEN-1:0]             wdata,
  output logic                        rvalid,
  output logic [XLEN-1:0]             rdata,
  output logic [WORD_SELECT_SIZE-1:0] word_index,
  output logic                        done
);

  localparam int OFS = $clog2(LINE_SIZE);
  localparam int AW  = $clog2(MEM_WORDS);
  localparam int LW  = $clog2(READ_LATENCY) + 1;
  localparam logic [WORD_SELECT_SIZE-1:0] LAST_IDX = WORD_SELECT_SIZE'(WORDS_PER_LINE - 1);
  localparam logic [LW-1:0]               LAT_LAST = LW'(READ_LATENCY - 2);

  l2_responder_state_e         state_q, state_d;
  logic [WORD_SELECT_SIZE-1:0] idx_q, idx_d;
  logic [LW-1:0]               lat_q, lat_d;
  logic [AW-1:0]               base_q, base_d;
  logic [XLEN-1:0]             rdata_hold_q;

  logic [XLEN-1:0] line_s, base_full_s, ram_rdata_s;
  logic [AW-1:0]   line_base_s, ram_addr_s;
  logic            ram_we_s;
  logic            unused_base_s;

  // Line number scaled to a word address; bits above the store depth wrap away.
  assign line_s        = req_address >> OFS;
  assign base_full_s   = line_s << WORD_SELECT_SIZE;
  assign line_base_s   = base_full_s[AW-1:0];
  assign unused_base_s = ^base_full_s[XLEN-1:AW];

  assign ram_addr_s = base_q + AW'(idx_q);
  assign ram_we_s   = (state_q == WRITEBACK) && wvalid;

  l2_word_ram #(
    .XLEN      (XLEN),
    .MEM_WORDS (MEM_WORDS)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we_s),
    .addr  (ram_addr_s),
    .wdata (wdata),
    .rdata (ram_rdata_s)
  );

  // Next-state and transfer bookkeeping
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    lat_d   = lat_q;
    base_d  = base_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          base_d = line_base_s;
          idx_d  = '0;
          lat_d  = '0;
          if (req_type == STORE) begin
            state_d = WRITEBACK;
          end else if (READ_LATENCY > 1) begin
            state_d = LATENCY;
          end else begin
            state_d = FILL;
          end
        end else begin
          state_d = IDLE;
        end
      end
      LATENCY: begin
        if (lat_q == LAT_LAST) begin
          state_d = FILL;
        end else begin
          lat_d = lat_q + LW'(1);
        end
      end
      FILL: begin
        idx_d = idx_q + WORD_SELECT_SIZE'(1);
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
        end else begin
          state_d = FILL;
        end
      end
      WRITEBACK: begin
        if (wvalid) begin
          idx_d = idx_q + WORD_SELECT_SIZE'(1);
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            state_d = WRITEBACK;
          end
        end else begin
          state_d = WRITEBACK;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, counters, and last fill word held for idle cycles
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      lat_q        <= '0;
      base_q       <= '0;
      rdata_hold_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      lat_q   <= lat_d;
      base_q  <= base_d;
      if (rvalid) begin
        rdata_hold_q <= ram_rdata_s;
      end
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign rvalid     = (state_q == FILL);
  assign done       = (state_q == DONE);
  assign word_index = idx_q;
  assign rdata      = rvalid ? ram_rdata_s : rdata_hold_q;

endmodule

// File: tb/tb_l2_line_responder.sv
// Scoreboard bench for l2_line_responder: directed fill/writeback/abort
// scenarios with an independent monitor checking every rvalid and done.
module tb_l2_line_responder;
  import xentry_pkg::*;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  memory_operation_e req_type = LOAD;
  logic [31:0]       req_address = 32'h0;
  logic              wvalid = 1'b0;
  logic [31:0]       wdata = 32'h0;
  logic              rvalid;
  logic [31:0]       rdata;
  logic [2:0]        word_index;
  logic              done;

  typedef struct {
    int          cyc;
    logic [2:0]  idx;
    logic [31:0] data;
  } rexp_t;

  rexp_t       rq[$];
  int          dq[$];
  logic [31:0] model_mem [64];
  int          cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  l2_line_responder dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_type    (req_type),
    .req_address (req_address),
    .wvalid      (wvalid),
    .wdata       (wdata),
    .rvalid      (rvalid),
    .rdata       (rdata),
    .word_index  (word_index),
    .done        (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every presented fill word and done pulse must match the queue head
  always @(negedge clk) begin
    rexp_t e;
    if (rvalid) begin
      if (rq.size() == 0) begin
        check("rvalid_unexpected", 32'd1, 32'd0);
      end else begin
        e = rq.pop_front();
        check("rdata", rdata, e.data);
        check("rvalid_index", {29'd0, word_index}, {29'd0, e.idx});
        check("rvalid_cycle", cyc, e.cyc);
      end
    end
    if (done) begin
      if (dq.size() == 0) begin
        check("done_unexpected", 32'd1, 32'd0);
      end else begin
        check("done_cycle", cyc, dq.pop_front());
      end
    end
  end

  task automatic preload(input int addr, input logic [31:0] val);
    dut.u_ram.mem_q[addr] = val;
    model_mem[addr] = val;
  endtask

  // Called at a negedge; returns at the negedge after acceptance.
  task automatic send_req(input memory_operation_e t, input logic [31:0] a, output int acc);
    int n = 0;
    req_valid = 1'b1;
    req_type = t;
    req_address = a;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      check("req_accept_timeout", 32'd0, 32'd1);
      acc = -1;
    end else begin
      acc = cyc;
    end
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic push_fill(input int acc, input int base, input int nwords, input bit with_done);
    rexp_t e;
    for (int k = 0; k < nwords; k++) begin
      e.cyc = acc + 4 + k;
      e.idx = 3'(k);
      e.data = model_mem[base + k];
      rq.push_back(e);
    end
    if (with_done) dq.push_back(acc + 12);
  endtask

  task automatic drain();
    int n = 0;
    while ((rq.size() != 0 || dq.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_pending", rq.size() + dq.size(), 32'd0);
    @(negedge clk);
  endtask

  task automatic write_line(input int base, input logic [31:0] first, input bit stall);
    for (int k = 0; k < 8; k++) begin
      if (stall) begin
        wvalid = 1'b0;
        @(negedge clk);
      end
      wvalid = 1'b1;
      wdata = first + 32'(k);
      model_mem[base + k] = first + 32'(k);
      check("wb_index", {29'd0, word_index}, k);
      if (k == 7) dq.push_back(cyc + 1);
      @(negedge clk);
    end
    wvalid = 1'b0;
  endtask

  initial begin
    int acc, acc2;
    for (int i = 0; i < 64; i++) preload(i, 32'hDEAD_0000 + 32'(i));
    repeat (3) @(negedge clk);
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_rvalid", {31'd0, rvalid}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_word_index", {29'd0, word_index}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      preload(8 + i, 32'h100 + 32'(i));
      preload(i, 32'h200 + 32'(i));
    end

    // Fill of line 1, with a second request held valid while busy (wraps to line 0)
    send_req(LOAD, 32'h20, acc);
    push_fill(acc, 8, 8, 1'b1);
    send_req(LOAD, 32'h101C, acc2);
    check("busy_accept_cycle", acc2 - acc, 32'd13);
    push_fill(acc2, 0, 8, 1'b1);
    drain();

    // Writeback with wvalid low every other cycle
    send_req(STORE, 32'h40, acc);
    write_line(16, 32'hA0, 1'b1);
    drain();
    for (int i = 0; i < 8; i++) check("wb_mem", dut.u_ram.mem_q[16 + i], 32'hA0 + 32'(i));

    // Reset after the third fill word
    send_req(LOAD, 32'h20, acc);
    push_fill(acc, 8, 3, 1'b0);
    while (cyc < acc + 6) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort_rvalid", {31'd0, rvalid}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_req_ready", {31'd0, req_ready}, 32'd1);
    check("abort_word_index", {29'd0, word_index}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("abort_pending", rq.size(), 32'd0);
    for (int i = 0; i < 8; i++) check("abort_mem", dut.u_ram.mem_q[8 + i], 32'h100 + 32'(i));

    // Back-to-back writeback then fill of the same line
    send_req(STORE, 32'h60, acc);
    write_line(24, 32'hC0, 1'b0);
    send_req(LOAD, 32'h60, acc);
    push_fill(acc, 24, 8, 1'b1);
    drain();

    // A non-LOAD/STORE type behaves as a fill
    send_req(PREFETCH, 32'h40, acc);
    push_fill(acc, 16, 8, 1'b1);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
